seq_divider16: RTL

- Sequential restoring divider: the inverse of the team's shift-and-add multiplier datapath.
- Takes a 16-bit dividend and an 8-bit divisor; produces a 16-bit quotient and an 8-bit remainder.
- Resolves one quotient bit per clock and uses the same start / done_flag handshake and state-display output style as the multiplier top level.
- Feeds the 16-bit result bus and the seven-segment state display.

---
 rtl/seq_divider16_if.sv | 26 ++
 rtl/seq_divider16.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seq_divider16_if.sv
// Handshake and result bus between the sequential divider and its client.
// The client drives operands and start; the divider returns results, status and the display state.
interface seq_divider16_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  busy;
    logic                  done_flag;
    logic                  div_zero;
    logic [1:0]            state;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done_flag, div_zero, state
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done_flag, div_zero, state
    );
endinterface

// File: rtl/seq_divider16.sv
// Restoring divider: one quotient bit per clock, MSB first, start/done_flag handshake.
// A zero divisor completes on the start edge with an all-ones quotient and the dividend low byte as remainder.
module seq_divider16 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int CNT_W      = 5
) (
    input  logic           clk,
    input  logic           rst,
    seq_divider16_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W:0]    partial_q, partial_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dz_q, dz_d;

    logic [DIVISOR_W:0]        shifted;
    logic signed [DIVISOR_W:0] trial;

    // The partial remainder stays below the divisor, so the shifted value is under twice the
    // divisor and the difference always fits a DIVISOR_W+1 signed word.
    function automatic logic signed [DIVISOR_W:0] trial_sub(
        input logic [DIVISOR_W:0]   num,
        input logic [DIVISOR_W-1:0] den
    );
        return $signed(num) - $signed({1'b0, den});
    endfunction

    always_comb begin
        state_d   = state_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        dz_d      = dz_q;
        shifted   = {partial_q[DIVISOR_W-1:0], quot_q[DIVIDEND_W-1]};
        trial     = trial_sub(shifted, divisor_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    quot_d    = bus.dividend;
                    divisor_d = bus.divisor;
                    partial_d = '0;
                    cnt_d     = '0;
                    if (bus.divisor != '0) begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        dz_d    = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend[DIVISOR_W-1:0];
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (!trial[DIVISOR_W]) begin
                    partial_d = $unsigned(trial);
                    quot_d    = {quot_q[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    partial_d = shifted;
                    quot_d    = {quot_q[DIVIDEND_W-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rem_d   = partial_d[DIVISOR_W-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            quot_q    <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.busy      = busy_q;
    assign bus.done_flag = done_q;
    assign bus.div_zero  = dz_q;
    assign bus.state     = state_q;
endmodule
